i2s_rx_ctrl: RTL and testbench
==============================

Name: i2s_rx_ctrl

Overview:
- Run/stop sequencer for the I2S receive master.
- Gates the master `en` so capture starts and ends on whole stereo frames (WS falling edge = start of left slot).
- Counts captured frames and supports a finite frame count or continuous mode.
- Optionally drains the sample FIFO on stop, tracks overrun and produces done/status pulses for the register/IRQ layer.

Parameters:
- CW, 16, width of frame-count target and captured-frame counter.
- FLUSH_MAX, 32, max FIFO read pulses issued in FLUSH (FIFO depth).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle start command; ignored unless IDLE
- stop  in  1  one-cycle stop command; honoured in ARM/RUN
- flush_on_stop  in  1  config: drain FIFO after stop; sampled on start
- frame_target  in  CW  frames to capture; 0 = continuous; sampled on start
- clr_status  in  1  clears sticky overrun
- ws  in  1  word select from the I2S master (reset-high)
- fifo_wr  in  1  FIFO write strobe from the receive path
- fifo_full  in  1  FIFO full
- fifo_empty  in  1  FIFO empty
- en  out  1  enable to the I2S master
- fifo_rd  out  1  read pulse for draining
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on return to IDLE after a run
- overrun  out  1  sticky: fifo_wr while fifo_full
- frames  out  CW  frames captured in the current/last run

Behaviour:
- Synchronous active-low reset; all registers update on posedge clk only.
- Reset values:
  - state = IDLE.
  - en = fifo_rd = busy = done = overrun = 0.
  - frames = 0; ws_q = 1.
- WS fall detection: ws_fall = ~ws & ws_q, where ws_q is ws registered one cycle.
- IDLE:
  - On start: latch frame_target and flush_on_stop, clear frames, go to ARM.
  - en rises the cycle after start (registered).
- ARM:
  - en = 1. Wait for the first ws_fall, then go to RUN. frames is not incremented.
  - stop in ARM: go to STOP_WAIT (no complete frame has been captured).
- RUN:
  - en = 1. Each ws_fall increments frames (saturating at all-ones).
  - If target != 0 and frames+1 == target on a ws_fall, go to DRAIN_DEC.
  - stop: go to STOP_WAIT.
- STOP_WAIT:
  - en stays 1 until the next ws_fall, which completes the current frame; frames increments only if entered from RUN.
  - Then go to DRAIN_DEC.
  - The master drops to en = 0 at a frame boundary, so ws is left low (left slot).
- DRAIN_DEC:
  - en = 0 from this state onward.
  - If the latched flush_on_stop = 1, go to FLUSH; otherwise go to IDLE with done = 1.
- FLUSH:
  - fifo_rd = 1 on each cycle where fifo_empty = 0, with a max of FLUSH_MAX pulses (count register).
  - Exit to IDLE with done = 1 when fifo_empty = 1 or the count reaches FLUSH_MAX.
  - fifo_rd is never asserted while fifo_empty = 1.
- Simultaneous events:
  - start+stop in IDLE: start wins; stop is ignored.
  - stop on the same cycle as the target-reached ws_fall: target path wins, go to DRAIN_DEC.
  - start outside IDLE: ignored.
- Overrun:
  - Set the cycle after fifo_wr & fifo_full in any state.
  - clr_status clears it; if set and clear coincide, set wins.
- frames holds its value in IDLE until the next start.
- Reset mid-operation (any state): immediate return to reset values; en falls at the next edge, with no done pulse.
- Latency: start to en = 1 cycle. Last ws_fall to en = 0 = 1 cycle.

Decomposition:
- Package i2s_ctrl_pkg:
  - state enum: IDLE, ARM, RUN, STOP_WAIT, DRAIN_DEC, FLUSH (3-bit).
  - localparam CW_DEFAULT.
- Sub-module i2s_edge_det (registered rise/fall detector, synchronous reset to a configurable level): used for ws. Everything else stays in one FSM module.

Test Plan:
- Target = 3, ws period 64 clk, flush off: start → en at +1 cycle; frames reaches 3 at the third ws_fall; en = 0 the next cycle; done pulse; busy = 0.
- Target = 0, stop mid-left-slot: en is held until the next ws_fall; frames increments once more; ws is low when en = 0.
- Flush on, FIFO holding 5 words (empty deasserts after 5 reads): exactly 5 fifo_rd pulses, then done; no rd while empty.
- fifo_wr with fifo_full → overrun = 1 next cycle; clr_status together with a new overrun event keeps overrun = 1; clr_status alone clears it.
- rst_n = 0 during RUN with frames = 2: next edge gives en = 0, state IDLE, frames = 0, no done pulse. start in IDLE together with stop still arms.
- Stop in ARM before the first ws_fall: frames stays 0; done follows the first ws_fall.

Source files
------------

// File: rtl/i2s_rx_ctrl_pkg.sv
// Shared types and defaults for the I2S receive run/stop sequencer.
package i2s_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    RUN       = 3'd2,
    STOP_WAIT = 3'd3,
    DRAIN_DEC = 3'd4,
    FLUSH     = 3'd5
  } state_t;

  localparam int unsigned CW_DEFAULT = 16;

endpackage

// File: rtl/i2s_rx_ctrl_if.sv
// Link between the sequencer, the I2S master (ws/en) and the sample FIFO.
interface i2s_rx_ctrl_if;

  logic ws;
  logic en;
  logic fifo_wr;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_rd;

  modport master (
    input  ws, fifo_wr, fifo_full, fifo_empty,
    output en, fifo_rd
  );

  modport slave (
    output ws, fifo_wr, fifo_full, fifo_empty,
    input  en, fifo_rd
  );

endinterface

// File: rtl/i2s_edge_det.sv
// Registered single-edge detector; the history flop resets to RST_LVL so
// no spurious edge is reported when reset releases.
module i2s_edge_det #(
  parameter logic RST_LVL  = 1'b0,
  parameter bit   DET_FALL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_edge
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) r_q <= RST_LVL;
    else        r_q <= i_d;
  end

  assign o_edge = DET_FALL ? (~i_d & r_q) : (i_d & ~r_q);

endmodule

// File: rtl/i2s_rx_ctrl.sv
// Run/stop sequencer for the I2S receive master: frame-aligned enable,
// frame counting, optional FIFO drain on stop, sticky overrun and done pulse.
module i2s_rx_ctrl
  import i2s_ctrl_pkg::*;
#(
  parameter int unsigned CW        = CW_DEFAULT,
  parameter int unsigned FLUSH_MAX = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          flush_on_stop,
  input  logic [CW-1:0] frame_target,
  input  logic          clr_status,
  i2s_rx_ctrl_if.master bus,
  output logic          busy,
  output logic          done,
  output logic          overrun,
  output logic [CW-1:0] frames
);

  localparam int unsigned   NW           = $clog2(FLUSH_MAX + 1);
  localparam logic [NW-1:0] LP_FLUSH_MAX = NW'(FLUSH_MAX);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_target;
  logic [CW-1:0] r_frames, w_frames_nxt, w_frames_sat;
  logic [NW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic          r_flush;
  logic          r_from_run;
  logic          r_en;
  logic          r_done, w_done_nxt;
  logic          r_overrun;
  logic          w_fifo_rd;
  logic          w_ws_fall;
  logic          w_hit;

  i2s_edge_det #(
    .RST_LVL  (1'b1),
    .DET_FALL (1'b1)
  ) u_ws_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (bus.ws),
    .o_edge (w_ws_fall)
  );

  assign w_frames_sat = (r_frames == '1) ? r_frames : r_frames + CW'(1);
  assign w_hit        = (r_target != '0) && ((r_frames + CW'(1)) == r_target);
  assign w_cnt_inc    = r_cnt + NW'(1);

  always_comb begin
    w_state_nxt  = r_state;
    w_frames_nxt = r_frames;
    w_cnt_nxt    = r_cnt;
    w_done_nxt   = 1'b0;
    w_fifo_rd    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt  = ARM;
          w_frames_nxt = '0;
          w_cnt_nxt    = '0;
        end
      end
      ARM: begin
        if (stop)           w_state_nxt = STOP_WAIT;
        else if (w_ws_fall) w_state_nxt = RUN;
      end
      RUN: begin
        // A target-reaching frame boundary outranks a coincident stop.
        if (w_ws_fall) begin
          w_frames_nxt = w_frames_sat;
          if (w_hit)     w_state_nxt = DRAIN_DEC;
          else if (stop) w_state_nxt = STOP_WAIT;
        end else if (stop) begin
          w_state_nxt = STOP_WAIT;
        end
      end
      STOP_WAIT: begin
        if (w_ws_fall) begin
          if (r_from_run) w_frames_nxt = w_frames_sat;
          w_state_nxt = DRAIN_DEC;
        end
      end
      DRAIN_DEC: begin
        w_cnt_nxt = '0;
        if (r_flush) begin
          w_state_nxt = FLUSH;
        end else begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      FLUSH: begin
        if (bus.fifo_empty) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_fifo_rd = 1'b1;
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == LP_FLUSH_MAX) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_frames   <= '0;
      r_cnt      <= '0;
      r_target   <= '0;
      r_flush    <= 1'b0;
      r_from_run <= 1'b0;
      r_en       <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_frames  <= w_frames_nxt;
      r_cnt     <= w_cnt_nxt;
      r_done    <= w_done_nxt;
      r_en      <= (w_state_nxt == ARM) || (w_state_nxt == RUN) ||
                   (w_state_nxt == STOP_WAIT);
      r_overrun <= (bus.fifo_wr & bus.fifo_full) | (r_overrun & ~clr_status);
      if (r_state == IDLE && start) begin
        r_target <= frame_target;
        r_flush  <= flush_on_stop;
      end
      if (w_state_nxt == STOP_WAIT && r_state != STOP_WAIT)
        r_from_run <= (r_state == RUN);
    end
  end

  assign bus.en      = r_en;
  assign bus.fifo_rd = w_fifo_rd;
  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign overrun     = r_overrun;
  assign frames      = r_frames;

endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// Bench for i2s_rx_ctrl: directed run table, randomized runs against an
// event-level model, plus overrun and reset sequences.
module tb_i2s_rx_ctrl;

  localparam int FMAX = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, flush_on_stop, clr_status;
  logic [15:0] frame_target;
  logic        busy, done, overrun;
  logic [15:0] frames;

  i2s_rx_ctrl_if bus ();

  i2s_rx_ctrl #(
    .CW        (16),
    .FLUSH_MAX (FMAX)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stop          (stop),
    .flush_on_stop (flush_on_stop),
    .frame_target  (frame_target),
    .clr_status    (clr_status),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .overrun       (overrun),
    .frames        (frames)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc_n = 0;
  int P     = 64;
  int ph    = 0;
  int lvl   = 0;
  int n0    = 0;

  bit mon_on  = 1'b0;
  bit rd_seen = 1'b0;
  bit en_prev = 1'b0;
  int en_cnt, busy_cnt, rd_cnt, done_cnt, done_rel, rd_bad, ws_at_off, en_first;

  typedef struct {
    int sp;   int tgt;  int stp;  bit fl;   int lvl;
    int e_fr; int e_en; int e_rd; int e_d;
  } vec_t;
  vec_t vt[7];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // I2S word select as seen at edge n: low for the left slot (first half).
  function automatic bit wsval(input int n);
    return ((n + ph) % P) >= (P / 2);
  endfunction

  function automatic bit is_fall(input int n);
    return !wsval(n) && wsval(n - 1);
  endfunction

  function automatic int fall_after(input int base, input int k);
    int j = k + 1;
    while (!is_fall(base + j)) j++;
    return j;
  endfunction

  task automatic step();
    @(posedge clk);
    cyc_n++;
    #1;
    if (rd_seen && lvl > 0) lvl--;
    bus.fifo_empty = (lvl == 0);
    bus.ws         = wsval(cyc_n + 1);
  endtask

  always @(negedge clk) begin
    rd_seen = bus.fifo_rd;
    if (mon_on) begin
      if (bus.en) begin
        en_cnt++;
        if (en_first < 0) en_first = cyc_n - n0;
      end
      if (busy)        busy_cnt++;
      if (bus.fifo_rd) rd_cnt++;
      if (bus.fifo_rd && bus.fifo_empty) rd_bad++;
      if (done) begin
        done_cnt++;
        done_rel = cyc_n - n0;
      end
      if (en_prev && !bus.en) ws_at_off = int'(bus.ws);
      en_prev = bus.en;
    end
  end

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 2000) begin
      step();
      g++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic align(input int sp);
    int g = 0;
    while (((cyc_n + 1 + ph) % P) != sp && g < 200) begin
      step();
      g++;
    end
  endtask

  // One complete run: start sampled at edge n0, optional stop at n0+s.
  task automatic run_case(input string tag, input int T, input int s, input bit fl,
                          input int L, input bit stop_with_start, input int e_fr,
                          input int e_en, input int e_rd, input int e_d);
    en_cnt = 0; busy_cnt = 0; rd_cnt = 0; done_cnt = 0; done_rel = -1;
    rd_bad = 0; ws_at_off = -1; en_first = -1; en_prev = 1'b0;
    lvl = L;
    bus.fifo_empty = (lvl == 0);
    frame_target  = 16'(T);
    flush_on_stop = fl;
    start         = 1'b1;
    stop          = stop_with_start;
    n0     = cyc_n + 1;
    mon_on = 1'b1;
    step();
    start = 1'b0; stop = 1'b0; flush_on_stop = 1'b0; frame_target = '0;
    for (int i = 0; i < e_d + 4; i++) begin
      stop = (s != 0) && (cyc_n + 1 == n0 + s);
      step();
    end
    stop   = 1'b0;
    mon_on = 1'b0;
    chk({tag, "_frames"},   int'(frames), e_fr);
    chk({tag, "_en_first"}, en_first, 0);
    chk({tag, "_en_cyc"},   en_cnt, e_en);
    chk({tag, "_rd_cnt"},   rd_cnt, e_rd);
    chk({tag, "_rd_empty"}, rd_bad, 0);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_at"},  done_rel, e_d);
    chk({tag, "_busy_cyc"}, busy_cnt, e_d);
    chk({tag, "_ws_at_off"}, ws_at_off, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int T, s, L, k1, kh, k, m, ef, efr, erd, ed;
    bit fl;

    // sp, target, stop, flush, level, frames, en cycles, rd pulses, done edge
    vt[0] = '{10, 3,   0, 1'b0,  0, 3, 246, 0, 247};
    vt[1] = '{10, 0, 140, 1'b0,  0, 2, 182, 0, 183};
    vt[2] = '{10, 1,   0, 1'b1,  5, 1, 118, 5, 125};
    vt[3] = '{10, 2,   0, 1'b1, 12, 2, 182, 8, 191};
    vt[4] = '{10, 0,  20, 1'b0,  0, 0,  54, 0,  55};
    vt[5] = '{10, 1,   0, 1'b1,  0, 1, 118, 0, 120};
    vt[6] = '{10, 2, 182, 1'b0,  0, 2, 182, 0, 183};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; flush_on_stop = 1'b0;
    clr_status = 1'b0; frame_target = '0;
    bus.ws = 1'b1; bus.fifo_wr = 1'b0; bus.fifo_full = 1'b0; bus.fifo_empty = 1'b1;
    repeat (3) step();
    chk("rst_en",      int'(bus.en), 0);
    chk("rst_fifo_rd", int'(bus.fifo_rd), 0);
    chk("rst_busy",    int'(busy), 0);
    chk("rst_done",    int'(done), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_frames",  int'(frames), 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      wait_idle();
      align(vt[i].sp);
      run_case($sformatf("vec%0d", i), vt[i].tgt, vt[i].stp, vt[i].fl, vt[i].lvl,
               1'b0, vt[i].e_fr, vt[i].e_en, vt[i].e_rd, vt[i].e_d);
    end

    // Randomized runs against the event-level model.
    for (int r = 0; r < 20; r++) begin
      wait_idle();
      P  = 8 << $urandom_range(0, 3);
      ph = int'($urandom_range(0, P - 1));
      step(); step();
      T  = int'($urandom_range(0, 3));
      fl = 1'($urandom_range(0, 1));
      L  = int'($urandom_range(0, 12));
      n0 = cyc_n + 1;
      k1 = fall_after(n0, 0);
      s  = 0;
      if (T == 0 || $urandom_range(0, 1) == 1) begin
        s = int'($urandom_range(1, 5 * P));
        if (s == k1) s++;
      end
      kh = k1;
      for (int i = 0; i < T; i++) kh = fall_after(n0, kh);
      if (s == 0 || (T != 0 && kh <= s)) begin
        ef = kh; efr = T;
      end else if (s < k1) begin
        ef = fall_after(n0, s); efr = 0;
      end else begin
        m = 0;
        k = fall_after(n0, k1);
        while (k <= s) begin
          m++;
          k = fall_after(n0, k);
        end
        ef = k; efr = m + 1;
      end
      erd = fl ? ((L < FMAX) ? L : FMAX) : 0;
      ed  = !fl ? ef + 1 : ((L < FMAX) ? ef + 2 + L : ef + 1 + FMAX);
      run_case($sformatf("rnd%0d", r), T, s, fl, L, 1'b0, efr, ef, erd, ed);
    end

    // Overrun: set on write-while-full, sticky, set beats clear.
    wait_idle();
    chk("ovr_init", int'(overrun), 0);
    bus.fifo_wr = 1'b1; bus.fifo_full = 1'b0; step();
    bus.fifo_wr = 1'b0; step();
    chk("ovr_wr_not_full", int'(overrun), 0);
    bus.fifo_wr = 1'b1; bus.fifo_full = 1'b1; step();
    bus.fifo_wr = 1'b0; bus.fifo_full = 1'b0;
    chk("ovr_set", int'(overrun), 1);
    step();
    chk("ovr_sticky", int'(overrun), 1);
    clr_status = 1'b1; bus.fifo_wr = 1'b1; bus.fifo_full = 1'b1; step();
    clr_status = 1'b0; bus.fifo_wr = 1'b0; bus.fifo_full = 1'b0;
    chk("ovr_set_wins", int'(overrun), 1);
    clr_status = 1'b1; step();
    clr_status = 1'b0;
    chk("ovr_clr", int'(overrun), 0);

    // Reset during RUN once two frames are in.
    P = 16; ph = 0;
    step(); step();
    frame_target = '0; start = 1'b1; step();
    start = 1'b0;
    for (int g = 0; g < 200 && frames != 16'd2; g++) step();
    chk("mid_frames2", int'(frames), 2);
    rst_n = 1'b0; step();
    chk("mid_rst_en",     int'(bus.en), 0);
    chk("mid_rst_busy",   int'(busy), 0);
    chk("mid_rst_frames", int'(frames), 0);
    rst_n = 1'b1;
    done_cnt = 0; mon_on = 1'b1;
    repeat (5) step();
    mon_on = 1'b0;
    chk("mid_rst_no_done", done_cnt, 0);

    // start+stop together in IDLE still arms; the stop in ARM then waits a frame.
    align(1);
    run_case("start_stop", 0, 1, 1'b0, 0, 1'b1, 0, 15, 0, 16);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
